// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 word-stream demultiplexer.
//   LANE_A / LANE_B : values of the per-word select bit
//   LANE_DEPTH      : entries per lane buffer
//   lane_occ_e      : lane buffer occupancy state
package demux_pkg;

    localparam logic        LANE_A     = 1'b0;
    localparam logic        LANE_B     = 1'b1;
    localparam int unsigned LANE_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } lane_occ_e;

endpackage : demux_pkg

// File: rtl/demux_lane_buf.sv
// Two-entry FIFO for one output lane. The head entry drives the lane output
// directly from a flop; a second entry absorbs one word while the consumer stalls.
//   clk, rst_n : clock, async active-low reset (flushes the buffer)
//   push       : write push_data this cycle (caller guarantees !full)
//   push_data  : word to enqueue
//   full       : occupancy is two (registered-state only, no path from out_ready)
//   out_data   : head word
//   out_valid  : head word valid
//   out_ready  : consumer accepts head word
module demux_lane_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    lane_occ_e        occ_q,   occ_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] tail_q,  tail_d;
    logic             valid_q, valid_d;
    logic             pop;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    // Occupancy transitions and entry updates
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        pop    = valid_q && out_ready;

        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                unique case ({push, pop})
                    2'b11: head_d = push_data;          // head advances straight to the new word
                    2'b10: begin
                        tail_d = push_data;
                        occ_d  = OCC_TWO;
                    end
                    2'b01: occ_d = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                // a full lane never takes a push, even when popping this cycle
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase

        valid_d = (occ_d != OCC_EMPTY);
    end

    assign full      = (occ_q == OCC_TWO);
    assign out_data  = head_q;
    assign out_valid = valid_q;

endmodule : demux_lane_buf

// File: rtl/demux_1to2_32bit_stream.sv
// Steers a valid/ready word stream to lane A or lane B by a per-word select bit.
// Each lane has an independent two-entry buffer; per-lane counters tally accepted words.
//   clk, rst_n             : clock, async active-low reset
//   in_data/in_select      : offered word and its lane (0 = A, 1 = B)
//   in_valid/in_ready      : producer handshake; in_ready = lane selected is not full
//   out_a_* / out_b_*      : lane output handshakes, driven from flops
//   cnt_a / cnt_b          : wrapping count of words accepted per lane
module demux_1to2_32bit_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_b_data,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    logic             full_a, full_b;
    logic             in_xfer;
    logic             push_a, push_b;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Ready follows the selected lane only, so the unselected lane never blocks.
    assign in_ready = (in_select == LANE_B) ? !full_b : !full_a;
    assign in_xfer  = in_valid && in_ready;
    assign push_a   = in_xfer && (in_select == LANE_A);
    assign push_b   = in_xfer && (in_select == LANE_B);

    demux_lane_buf #(.WIDTH(WIDTH)) u_lane_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (in_data),
        .full      (full_a),
        .out_data  (out_a_data),
        .out_valid (out_a_valid),
        .out_ready (out_a_ready)
    );

    demux_lane_buf #(.WIDTH(WIDTH)) u_lane_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (in_data),
        .full      (full_b),
        .out_data  (out_b_data),
        .out_valid (out_b_valid),
        .out_ready (out_b_ready)
    );

    // Accepted-word counters, wrapping naturally
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (push_a) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (push_b) cnt_b_d = cnt_b_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;

endmodule : demux_1to2_32bit_stream

// File: doc/demux_1to2_32bit_stream.md
# demux_1to2_32bit_stream

Routes a 32-bit word stream to one of two output lanes, A or B. The lane is chosen per word by a select bit that travels with the data. It is the inverse of the datapath's 2-to-1 word selection: where the selector merges two sources into one, this block steers one producer to two consumers. Each lane has its own 2-entry buffer, so a stalled lane never corrupts or reorders words already queued on the other lane.

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 16, width of per-lane accepted-word counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word offered by producer
- in_select  input  1  0 = lane A, 1 = lane B; qualified by in_valid
- in_valid  input  1  producer offers in_data/in_select
- in_ready  output  1  block accepts the offered word this cycle
- out_a_data  output  WIDTH  lane A head word
- out_a_valid  output  1  lane A head valid
- out_a_ready  input  1  lane A consumer accepts
- out_b_data  output  WIDTH  lane B head word
- out_b_valid  output  1  lane B head valid
- out_b_ready  input  1  lane B consumer accepts
- cnt_a  output  CNT_W  words accepted into lane A since reset, wraps
- cnt_b  output  CNT_W  words accepted into lane B since reset, wraps

## Operation
- Handshake on every port: a transfer occurs on a cycle when valid and ready are both high at the rising edge of clk.
- Valid, once raised, stays high with stable data until the transfer. The producer and both consumers follow this rule, and the block guarantees it on out_a and out_b.
- in_ready = NOT full(lane chosen by in_select). It depends on in_select even when in_valid is low.
- in_ready has no combinational path from out_a_ready or out_b_ready. A full lane does not accept a word in the same cycle it pops one.
- Lane buffer: 2-entry FIFO with occupancy 0, 1 or 2.
  - Push on input transfer to that lane. Pop on output transfer of that lane.
  - Push and pop in the same cycle at occupancy 1 leave occupancy at 1; the head advances to the pushed word.
  - Pop at occupancy 0 cannot occur, because out_*_valid is low.
- Ordering is FIFO within a lane. The two lanes are independent.
- Counters: cnt_a and cnt_b increment on each input transfer to their lane. Wrap 2^CNT_W−1 → 0.
- Reset mid-operation: asserting rst_n low flushes both lanes immediately. Buffered words are discarded, not delivered.
- Reset values: out_a_valid=0, out_b_valid=0, out_a_data=0, out_b_data=0, cnt_a=0, cnt_b=0. in_ready=1 after reset, because both lanes are empty.

## Timing
- Latency: a word accepted at edge N is presented as valid on its lane output after edge N, so it is available for transfer at edge N+1.
- Throughput: 1 word/cycle into either lane while that lane's consumer holds ready high.
- Alternating selects A,B,A,B… with both consumers ready sustain 1 word/cycle with no bubbles.
- A lane with its consumer stalled accepts exactly 2 words. in_ready then drops, but only while in_select points at that lane.
- Head-of-line: if the producer holds a word for a full lane, the other lane keeps draining but receives nothing new. The producer does not reorder its own stream.
- All state is registered. Outputs are driven from flops, except in_ready, which is combinational from the occupancy registers and in_select.

## Structure
- Shared package demux_pkg: constant LANE_A=1'b0, LANE_B=1'b1, and the FIFO depth constant LANE_DEPTH=2.
- Sub-module demux_lane_buf (params WIDTH):
  - Ports: push, push_data, full, out_data, out_valid, out_ready.
  - Contains the 2-entry FIFO with an occupancy register.
  - Instantiated twice.
- The top level holds the push steering, the in_ready mux and the two counters.

## Test plan
- Reset, then send 0xDEADBEEF to A and 0x12345678 to B on consecutive cycles with both consumers ready. Each word appears one cycle after acceptance on the correct lane; cnt_a=1, cnt_b=1.
- out_a_ready=0. Send 3 words to A (0x1, 0x2, 0x3). The first two are accepted and in_ready drops on the third. Switch in_select to B: in_ready=1 and the B word passes. Release out_a_ready: A delivers 0x1 then 0x2 in order, and 0x3 is then accepted.
- Lane A at occupancy 1 with simultaneous push 0xA5A5A5A5 and pop: occupancy stays 1 and the head becomes 0xA5A5A5A5 on the next cycle.
- Stream 100 words alternating A/B with both consumers ready: in_ready stays high throughout and cnt_a=cnt_b=50.
- Preload cnt_b to 0xFFFF by sending 65535 words to B, then send one more word. cnt_b=0x0000 and cnt_a is unchanged.
- Fill both lanes, then assert rst_n low mid-cycle. out_*_valid go low asynchronously, and after release both counters read 0 with no stale word delivered.
